gaussian_column_feeder: RTL and testbench
=========================================

# gaussian_column_feeder

Reads a raster-stored image from a synchronous image memory, one pixel per cycle, and buffers the previous four rows in line buffers. From row 4 onward it presents a vertical 5-pixel column every cycle, with a contiguous `col_enable`, to the 5×5 Gaussian filter's `pixel_in0..4` / `enable` inputs. It is the producer side of the filter's column-stream interface and sits between the image SRAM and the filter.

## Interface
- `WIDTH`, 32, image width in pixels (≥5)
- `HEIGHT`, 32, image height in rows (≥5)
- `BIT_LENGTH`, 5, pixel width (shared package constant)
- `AW`, clog2(WIDTH*HEIGHT), memory address width
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  one-cycle pulse; honoured only in IDLE
- `mem_rd`  out  1  read strobe to image memory
- `mem_addr`  out  AW  raster address y*WIDTH+x
- `mem_data`  in  BIT_LENGTH  read data, valid the cycle after `mem_rd`/`mem_addr`
- `col_out0..col_out4`  out  BIT_LENGTH each  column, row y-4 (out0, top) … row y (out4); drives filter `pixel_in0..4`
- `col_enable`  out  1  drives filter `enable`
- `busy`  out  1  high in READ/DRAIN
- `done`  out  1  high in DONE; held until reset

## Operation
- Reset values: all outputs 0, address counter 0, line buffers 0, state IDLE.
- FSM: IDLE → READ on `start`; READ → DRAIN after issuing address WIDTH*HEIGHT-1; DRAIN → DONE when the last pixel is captured; DONE is terminal (`start` ignored), because the filter's end-of-stream state is terminal. Leaving DONE requires `reset`.
- READ: `mem_rd`=1 and `mem_addr` increments by 1 every cycle from 0. There are no stalls.
- A 1-bit valid pipe (`mem_rd` delayed one cycle) marks returning data. x/y capture counters advance only on valid returns. x wraps at WIDTH-1, then y increments.
- On each valid return, the pixel is shifted into the line buffer chain:
  - row buffer 3 → row buffer 2 → row buffer 1 → row buffer 0, each WIDTH deep.
  - The outputs register {rb0 tail, rb1 tail, rb2 tail, rb3 tail, new pixel} into `col_out0..4`.
- `col_enable` is registered alongside the column. It is 1 exactly for the captures with y ≥ 4, i.e. (HEIGHT-4)*WIDTH consecutive cycles. It is never high with a gap.
- Columns with y < 4 are still driven onto `col_out*` (partial rows, enable low). The filter shifts regardless of enable.
- No border padding. The downstream collector discards outputs whose window straddles a row boundary, i.e. the first 4 columns of each row. The feeder does not flag these.
- Arithmetic: counters are unsigned. `mem_addr` never exceeds WIDTH*HEIGHT-1.

## Timing
- Let E0 be the edge sampling `start`=1 in IDLE.
- After edge E0+k, for k = 0..W*H-1: `mem_addr`=k and `mem_rd`=1. After edge E0+W*H: `mem_rd`=0 and `mem_addr` holds its last value.
- The column for pixel k is visible after edge E0+k+2 (two-cycle latency: memory, then output register).
- `col_enable` rises after edge E0+4W+2 and falls after edge E0+W*H+2. `done` and DONE are entered at that same edge, and `busy` falls there.
- `start` asserted while busy or done: ignored.
- Reset mid-operation: outputs go to 0 asynchronously, and the in-flight memory return is discarded.

## Structure
- Shared package: `BIT_LENGTH`, state encodings (IDLE/READ/DRAIN/DONE), and the clog2 helper.
- Sub-module `line_buffer_row`: WIDTH-deep, BIT_LENGTH-wide shift register with a shift enable and async reset. Instantiated 4×.
- Top: FSM, address counter, capture x/y counters, valid pipe, output registers.

## Test plan
- Basic, W=8, H=6, memory[a] = a mod 32: `start` → `mem_addr` 0..47 on consecutive cycles. The first enabled column (x=0, y=4) is {0,8,16,24,0}: address 32 mod 32 = 0, because the modulo wraps the 5-bit values. `col_enable` is high for 16 cycles, and `done` rises at E0+50.
- Contiguity: same image; count `col_enable` cycles = (H-4)*W with no low cycle between the rise and the fall. Check `col_out4` = memory[k] at E0+k+2 for every k.
- `start` re-pulsed during READ and during DONE → no change to address sequence; `done` stays 1; `mem_rd` stays 0 after completion.
- Reset asserted at E0+20 → all outputs 0 immediately. A new `start` restarts from address 0, and the first enabled column matches the basic case.
- Minimum image W=5, H=5, constant pixel 31 → exactly 5 enabled cycles, all columns {31,31,31,31,31}. With the filter attached, its output reads 31 or 30, i.e. within 1 LSB of 31 (its divide is approximate).
- Idle: no `start` for 100 cycles → `mem_rd`, `col_enable`, `busy` and `done` all 0.

Source files
------------

// File: rtl/gaussian_column_feeder_pkg.sv
// Shared constants, FSM encoding and the address-width helper for the column feeder.
package gaussian_column_feeder_pkg;

    localparam int BIT_LENGTH = 5;

    typedef logic [BIT_LENGTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/gaussian_column_feeder_if.sv
// Memory read port plus column stream towards the 5x5 Gaussian filter.
interface gaussian_column_feeder_if #(
    parameter int AW = 10
);
    import gaussian_column_feeder_pkg::*;

    logic          start;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    pixel_t        mem_data;
    pixel_t        col_out0;
    pixel_t        col_out1;
    pixel_t        col_out2;
    pixel_t        col_out3;
    pixel_t        col_out4;
    logic          col_enable;
    logic          busy;
    logic          done;

    modport master (
        input  start, mem_data,
        output mem_rd, mem_addr,
        output col_out0, col_out1, col_out2, col_out3, col_out4,
        output col_enable, busy, done
    );

    modport slave (
        output start, mem_data,
        input  mem_rd, mem_addr,
        input  col_out0, col_out1, col_out2, col_out3, col_out4,
        input  col_enable, busy, done
    );

endinterface

// File: rtl/gaussian_column_feeder_line_buffer_row.sv
// One image row of delay: WIDTH-deep pixel shift register, tail is the pixel from WIDTH shifts ago.
// No backpressure; shifts only when shift_en is high.
module line_buffer_row
    import gaussian_column_feeder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   shift_en,
    input  pixel_t din,
    output pixel_t tail
);

    pixel_t taps [WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                taps[i] <= '0;
            end
        end else if (shift_en) begin
            taps[0] <= din;
            for (int i = 1; i < WIDTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign tail = taps[WIDTH-1];

endmodule

// File: rtl/gaussian_column_feeder.sv
// Raster reader feeding 5-pixel vertical columns to the Gaussian filter; column appears 2 cycles after its address.
// No stalls: one read per cycle, the filter must accept every column.
module gaussian_column_feeder
    import gaussian_column_feeder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int AW     = clog2(WIDTH*HEIGHT)
) (
    input logic                      clk,
    input logic                      reset,
    gaussian_column_feeder_if.master bus
);

    localparam int XW = clog2(WIDTH);
    localparam int YW = clog2(HEIGHT + 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(WIDTH*HEIGHT - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_FIRST   = YW'(4);

    state_t        state, state_nxt;
    logic [AW-1:0] addr;
    logic          rd;
    logic          vld;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    pixel_t        tail [4];
    pixel_t        col  [5];
    logic          col_en;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = READ;
            READ:    if (addr == ADDR_LAST) state_nxt = DRAIN;
            // vld low in DRAIN means the final pixel was captured on the previous edge.
            DRAIN:   if (!vld) state_nxt = DONE;
            default: state_nxt = DONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            rd    <= 1'b0;
            vld   <= 1'b0;
        end else begin
            state <= state_nxt;
            vld   <= rd;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        rd   <= 1'b1;
                        addr <= '0;
                    end
                end
                READ: begin
                    if (addr == ADDR_LAST) rd <= 1'b0;
                    else                   addr <= addr + AW'(1);
                end
                default: rd <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            col_en <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                col[i] <= '0;
            end
        end else if (vld) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
            col[0] <= tail[0];
            col[1] <= tail[1];
            col[2] <= tail[2];
            col[3] <= tail[3];
            col[4] <= bus.mem_data;
            col_en <= (y >= Y_FIRST);
        end else begin
            col_en <= 1'b0;
        end
    end

    // Newest row enters buffer 3; each buffer's tail feeds the next-older row buffer.
    line_buffer_row #(.WIDTH(WIDTH)) u_rb3 (.clk(clk), .reset(reset), .shift_en(vld), .din(bus.mem_data), .tail(tail[3]));
    line_buffer_row #(.WIDTH(WIDTH)) u_rb2 (.clk(clk), .reset(reset), .shift_en(vld), .din(tail[3]),      .tail(tail[2]));
    line_buffer_row #(.WIDTH(WIDTH)) u_rb1 (.clk(clk), .reset(reset), .shift_en(vld), .din(tail[2]),      .tail(tail[1]));
    line_buffer_row #(.WIDTH(WIDTH)) u_rb0 (.clk(clk), .reset(reset), .shift_en(vld), .din(tail[1]),      .tail(tail[0]));

    assign bus.mem_rd     = rd;
    assign bus.mem_addr   = addr;
    assign bus.col_out0   = col[0];
    assign bus.col_out1   = col[1];
    assign bus.col_out2   = col[2];
    assign bus.col_out3   = col[3];
    assign bus.col_out4   = col[4];
    assign bus.col_enable = col_en;
    assign bus.busy       = (state == READ) || (state == DRAIN);
    assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_gaussian_column_feeder.sv
// Bench for gaussian_column_feeder: 8x6 frames with a reference column model, plus a 5x5 constant image.
module tb_gaussian_column_feeder;
    import gaussian_column_feeder_pkg::*;

    localparam int WA  = 8;
    localparam int HA  = 6;
    localparam int NA  = WA * HA;
    localparam int AWA = clog2(NA);
    localparam int WB  = 5;
    localparam int HB  = 5;
    localparam int NB  = WB * HB;
    localparam int AWB = clog2(NB);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_b;

    gaussian_column_feeder_if #(.AW(AWA)) bus_a ();
    gaussian_column_feeder_if #(.AW(AWB)) bus_b ();

    gaussian_column_feeder #(.WIDTH(WA), .HEIGHT(HA), .AW(AWA)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    gaussian_column_feeder #(.WIDTH(WB), .HEIGHT(HB), .AW(AWB)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    pixel_t img_a [NA];
    pixel_t img_b [NB];

    // Synchronous image memories: data for an address appears one cycle later.
    always @(posedge clk) begin
        if (int'(bus_a.mem_addr) < NA) bus_a.mem_data <= img_a[bus_a.mem_addr];
        if (int'(bus_b.mem_addr) < NB) bus_b.mem_data <= img_b[bus_b.mem_addr];
    end

    int compared   = 0;
    int mismatched = 0;
    logic [24:0] first_col_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Column row j for pixel k is the pixel (4-j) rows above it, or 0 before any such row was read.
    function automatic logic [31:0] ref_col(input int k, input int j);
        int src;
        src = k - (4 - j) * WA;
        return (src < 0) ? 32'd0 : 32'(img_a[src]);
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, " mem_rd"},     bus_a.mem_rd,     0);
        chk({tag, " mem_addr"},   bus_a.mem_addr,   0);
        chk({tag, " col_out0"},   bus_a.col_out0,   0);
        chk({tag, " col_out1"},   bus_a.col_out1,   0);
        chk({tag, " col_out2"},   bus_a.col_out2,   0);
        chk({tag, " col_out3"},   bus_a.col_out3,   0);
        chk({tag, " col_out4"},   bus_a.col_out4,   0);
        chk({tag, " col_enable"}, bus_a.col_enable, 0);
        chk({tag, " busy"},       bus_a.busy,       0);
        chk({tag, " done"},       bus_a.done,       0);
    endtask

    // Pulses start, then checks every cycle from E0 to a few cycles past DONE.
    task automatic run_a(input string tag, input bit repulse);
        int k;
        int en_cnt;
        int first_en;
        int last_en;
        en_cnt   = 0;
        first_en = -1;
        last_en  = -1;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int t = 0; t <= NA + 5; t++) begin
            k = t - 2;
            chk($sformatf("%s mem_rd t=%0d", tag, t),   bus_a.mem_rd,   32'(t < NA));
            chk($sformatf("%s mem_addr t=%0d", tag, t), bus_a.mem_addr, (t < NA) ? t : NA - 1);
            if (k >= 0 && k < NA) begin
                chk($sformatf("%s col0 k=%0d", tag, k), bus_a.col_out0, ref_col(k, 0));
                chk($sformatf("%s col1 k=%0d", tag, k), bus_a.col_out1, ref_col(k, 1));
                chk($sformatf("%s col2 k=%0d", tag, k), bus_a.col_out2, ref_col(k, 2));
                chk($sformatf("%s col3 k=%0d", tag, k), bus_a.col_out3, ref_col(k, 3));
                chk($sformatf("%s col4 k=%0d", tag, k), bus_a.col_out4, ref_col(k, 4));
            end
            chk($sformatf("%s col_enable t=%0d", tag, t), bus_a.col_enable, 32'(k >= 4 * WA && k < NA));
            chk($sformatf("%s busy t=%0d", tag, t),       bus_a.busy,       32'(t < NA + 2));
            chk($sformatf("%s done t=%0d", tag, t),       bus_a.done,       32'(t >= NA + 2));
            if (t == 4 * WA + 2) begin
                first_col_a = {bus_a.col_out0, bus_a.col_out1, bus_a.col_out2, bus_a.col_out3, bus_a.col_out4};
            end
            if (bus_a.col_enable === 1'b1) begin
                en_cnt++;
                if (first_en < 0) first_en = t;
                last_en = t;
            end
            bus_a.start = repulse && (t == 10 || t == NA + 3);
            tick();
        end
        bus_a.start = 1'b0;
        chk({tag, " en_count"},  en_cnt,                (HA - 4) * WA);
        chk({tag, " en_contig"}, last_en - first_en + 1, en_cnt);
        chk({tag, " en_rise"},   first_en,              4 * WA + 2);
    endtask

    initial begin
        int en_b;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        for (int a = 0; a < NA; a++) img_a[a] = pixel_t'(a % 32);
        for (int a = 0; a < NB; a++) img_b[a] = pixel_t'(31);
        tick();
        tick();
        check_outputs_zero("reset");
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Idle without start.
        for (int i = 0; i < 100; i++) begin
            if (i % 25 == 0) begin
                chk("idle mem_rd",     bus_a.mem_rd,     0);
                chk("idle col_enable", bus_a.col_enable, 0);
                chk("idle busy",       bus_a.busy,       0);
                chk("idle done",       bus_a.done,       0);
            end
            tick();
        end

        // Basic ramp image.
        run_a("basic", 1'b0);
        chk("basic first_col", first_col_a, {5'd0, 5'd8, 5'd16, 5'd24, 5'd0});

        // Random image, start re-pulsed during READ and DONE.
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        for (int a = 0; a < NA; a++) img_a[a] = pixel_t'($urandom_range(0, 31));
        run_a("rand", 1'b1);

        // Reset mid-frame, then a clean restart.
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        for (int a = 0; a < NA; a++) img_a[a] = pixel_t'($urandom_range(0, 31));
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        reset_a = 1'b1;
        #1;
        check_outputs_zero("midreset");
        tick();
        reset_a = 1'b0;
        for (int a = 0; a < NA; a++) img_a[a] = pixel_t'(a % 32);
        run_a("restart", 1'b0);
        chk("restart first_col", first_col_a, {5'd0, 5'd8, 5'd16, 5'd24, 5'd0});

        // Minimum 5x5 image of constant 31.
        en_b = 0;
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int t = 0; t <= NB + 5; t++) begin
            if (bus_b.col_enable === 1'b1) begin
                en_b++;
                chk($sformatf("min col t=%0d", t),
                    {bus_b.col_out0, bus_b.col_out1, bus_b.col_out2, bus_b.col_out3, bus_b.col_out4},
                    {5'd31, 5'd31, 5'd31, 5'd31, 5'd31});
            end
            tick();
        end
        chk("min en_count", en_b,        (HB - 4) * WB);
        chk("min done",     bus_b.done,  1);
        chk("min busy",     bus_b.busy,  0);
        chk("min mem_rd",   bus_b.mem_rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
